// File: rtl/zynq_aes_perf_pkg.sv
// Shared definitions for the AES datapath performance monitors:
// parameter defaults, ingress tracker states and saturating arithmetic.
package zynq_aes_perf_pkg;

  localparam int unsigned CNT_W_DEF = 32;
  localparam int unsigned ACC_W_DEF = 48;
  localparam int unsigned REQ_W_DEF = 16;
  localparam int unsigned DEPTH_DEF = 4;

  typedef enum logic {
    IN_IDLE = 1'b0,
    IN_PKT  = 1'b1
  } in_state_e;

  // Sum clamped to the largest value representable in w bits (w <= 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    if (sum > lim) return lim[63:0];
    return sum[63:0];
  endfunction

endpackage

// File: rtl/perf_ts_fifo.sv
// Timestamp FIFO for outstanding requests; a pop frees its slot for a
// push in the same cycle, so push+pop on a full queue both proceed.
module perf_ts_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axis_latency_monitor.sv
// Passive AXI4-Stream latency monitor: timestamps each request's first
// ingress beat and pairs it with the next egress tlast beat.
module axis_latency_monitor
  import zynq_aes_perf_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned REQ_W = REQ_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   enable,
  input  logic                   clear,
  input  logic                   in_tvalid,
  input  logic                   in_tready,
  input  logic                   in_tlast,
  input  logic                   out_tvalid,
  input  logic                   out_tready,
  input  logic                   out_tlast,
  output logic [CNT_W-1:0]       lat_last,
  output logic [CNT_W-1:0]       lat_min,
  output logic [CNT_W-1:0]       lat_max,
  output logic [ACC_W-1:0]       lat_total,
  output logic [REQ_W-1:0]       req_count,
  output logic                   lat_valid,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   overflow,
  output logic                   underflow
);

  logic [CNT_W-1:0] ts;
  logic [CNT_W-1:0] head;
  logic [CNT_W-1:0] lat;
  in_state_e        state;
  logic             in_beat;
  logic             done;
  logic             start;
  logic             q_full;
  logic             q_empty;
  logic             stats_upd;

  assign in_beat   = enable && in_tvalid && in_tready;
  assign done      = enable && out_tvalid && out_tready && out_tlast;
  assign start     = in_beat && (state == IN_IDLE);
  assign lat       = ts - head;
  // Statistics are frozen once a timestamp was dropped: pairing is no longer trustworthy.
  assign stats_upd = done && !q_empty && !overflow;

  perf_ts_fifo #(
    .DEPTH (DEPTH),
    .W     (CNT_W)
  ) u_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .clear (clear),
    .push  (start && !clear),
    .pop   (done && !clear),
    .din   (ts),
    .head  (head),
    .full  (q_full),
    .empty (q_empty),
    .count (outstanding)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)    ts <= '0;
    else if (enable) ts <= ts + 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IN_IDLE;
    end else if (clear) begin
      state <= IN_IDLE;
    end else begin
      case (state)
        IN_IDLE: if (in_beat && !in_tlast) state <= IN_PKT;
        IN_PKT:  if (in_beat && in_tlast)  state <= IN_IDLE;
        default: state <= IN_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lat_last  <= '0;
      lat_min   <= '1;
      lat_max   <= '0;
      lat_total <= '0;
      req_count <= '0;
      lat_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      lat_last  <= '0;
      lat_min   <= '1;
      lat_max   <= '0;
      lat_total <= '0;
      req_count <= '0;
      lat_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      lat_valid <= stats_upd;
      if (stats_upd) begin
        lat_last  <= lat;
        if (lat < lat_min) lat_min <= lat;
        if (lat > lat_max) lat_max <= lat;
        lat_total <= ACC_W'(sat_add(64'(lat_total), 64'(lat), ACC_W));
        req_count <= REQ_W'(sat_add(64'(req_count), 64'd1, REQ_W));
      end
      if (done && q_empty)          underflow <= 1'b1;
      if (start && q_full && !done) overflow  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_latency_monitor.sv
// Directed bench for axis_latency_monitor with a queue-based reference
// model compared every cycle plus hand-computed spot checks.
module tb_axis_latency_monitor;

  localparam int CW = 8;
  localparam int AW = 10;
  localparam int RW = 4;
  localparam int D  = 4;
  localparam int TS_MASK = 255;
  localparam int ACC_MAX = 1023;
  localparam int REQ_MAX = 15;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic enable = 1'b0;
  logic clear = 1'b0;
  logic in_tvalid = 1'b0, in_tready = 1'b0, in_tlast = 1'b0;
  logic out_tvalid = 1'b0, out_tready = 1'b0, out_tlast = 1'b0;
  logic [CW-1:0] lat_last, lat_min, lat_max;
  logic [AW-1:0] lat_total;
  logic [RW-1:0] req_count;
  logic          lat_valid;
  logic [2:0]    outstanding;
  logic          overflow, underflow;

  int tests = 0;
  int fails = 0;

  axis_latency_monitor #(
    .CNT_W (CW),
    .ACC_W (AW),
    .REQ_W (RW),
    .DEPTH (D)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .enable      (enable),
    .clear       (clear),
    .in_tvalid   (in_tvalid),
    .in_tready   (in_tready),
    .in_tlast    (in_tlast),
    .out_tvalid  (out_tvalid),
    .out_tready  (out_tready),
    .out_tlast   (out_tlast),
    .lat_last    (lat_last),
    .lat_min     (lat_min),
    .lat_max     (lat_max),
    .lat_total   (lat_total),
    .req_count   (req_count),
    .lat_valid   (lat_valid),
    .outstanding (outstanding),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of start timestamps plus running statistics.
  int m_ts = 0;
  int q[$];
  bit m_pkt;
  int m_last, m_min, m_max, m_total, m_cnt;
  bit m_valid, m_ovf, m_unf;
  bit ib, od, st, ovf_old;
  int h, lat;

  task automatic model_clear();
    q.delete();
    m_pkt = 0; m_last = 0; m_min = TS_MASK; m_max = 0; m_total = 0; m_cnt = 0;
    m_valid = 0; m_ovf = 0; m_unf = 0;
  endtask

  initial model_clear();

  always @(posedge aclk) begin
    if (!aresetn) begin
      model_clear();
      m_ts = 0;
    end else begin
      ib = enable && in_tvalid && in_tready;
      od = enable && out_tvalid && out_tready && out_tlast;
      if (clear) begin
        model_clear();
      end else begin
        m_valid = 0;
        st = ib && !m_pkt;
        if (ib) m_pkt = !in_tlast;
        ovf_old = m_ovf;
        if (od) begin
          if (q.size() == 0) m_unf = 1;
          else begin
            h = q.pop_front();
            lat = (m_ts - h) & TS_MASK;
            if (!ovf_old) begin
              m_valid = 1;
              m_last = lat;
              if (lat < m_min) m_min = lat;
              if (lat > m_max) m_max = lat;
              m_total = (m_total + lat > ACC_MAX) ? ACC_MAX : m_total + lat;
              m_cnt = (m_cnt == REQ_MAX) ? REQ_MAX : m_cnt + 1;
            end
          end
        end
        if (st) begin
          if (q.size() < D) q.push_back(m_ts);
          else m_ovf = 1;
        end
      end
      if (enable) m_ts = (m_ts + 1) & TS_MASK;
    end
    #1;
    chk("lat_last", lat_last, m_last);
    chk("lat_min", lat_min, m_min);
    chk("lat_max", lat_max, m_max);
    chk("lat_total", lat_total, m_total);
    chk("req_count", req_count, m_cnt);
    chk("lat_valid", lat_valid, m_valid);
    chk("outstanding", outstanding, q.size());
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
  end

  // Called at a falling edge; the values are sampled by the next rising edge.
  task automatic step(input bit iv, input bit il, input bit ov, input bit ol, input bit cl);
    in_tvalid = iv; in_tready = iv; in_tlast = il;
    out_tvalid = ov; out_tready = ov; out_tlast = ol;
    clear = cl;
    @(negedge aclk);
    in_tvalid = 0; in_tready = 0; in_tlast = 0;
    out_tvalid = 0; out_tready = 0; out_tlast = 0;
    clear = 0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic wait_ts(input int t);
    int n;
    n = 0;
    while (m_ts != t && n < 600) begin
      idle();
      n++;
    end
    if (m_ts != t) begin
      tests++;
      fails++;
      $display("FAIL wait_ts: timeout, ts %0d expected %0d", m_ts, t);
    end
  endtask

  initial begin
    @(negedge aclk);
    @(negedge aclk);
    chk("rst_lat_min", lat_min, 255);
    chk("rst_req_count", req_count, 0);
    chk("rst_outstanding", outstanding, 0);
    aresetn = 1; enable = 1;

    // Single 4-beat request: start ts=10, tlast at ts=57.
    wait_ts(10);
    step(1, 0, 0, 0, 0);
    chk("t1_outstanding", outstanding, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("t1_outstanding_pkt", outstanding, 1);
    wait_ts(57);
    step(0, 0, 1, 1, 0);
    chk("t1_lat_valid", lat_valid, 1);
    chk("t1_lat_last", lat_last, 47);
    chk("t1_lat_min", lat_min, 47);
    chk("t1_lat_max", lat_max, 47);
    chk("t1_req_count", req_count, 1);
    idle();
    chk("t1_pulse", lat_valid, 0);

    // Three overlapping requests with latencies 30, 50, 40.
    step(0, 0, 0, 0, 1);
    wait_ts(100);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    wait_ts(120);
    step(1, 1, 0, 0, 0);
    chk("t2_outstanding_peak", outstanding, 3);
    wait_ts(130);
    step(0, 0, 1, 1, 0);
    chk("t2_lat_first", lat_last, 30);
    wait_ts(151);
    step(0, 0, 1, 1, 0);
    wait_ts(160);
    step(0, 0, 1, 1, 0);
    chk("t2_lat_min", lat_min, 30);
    chk("t2_lat_max", lat_max, 50);
    chk("t2_lat_total", lat_total, 120);
    chk("t2_req_count", req_count, 3);

    // Five starts against four slots.
    step(0, 0, 0, 0, 1);
    repeat (4) step(1, 1, 0, 0, 0);
    chk("t3_no_ovf_yet", overflow, 0);
    step(1, 1, 0, 0, 0);
    chk("t3_overflow", overflow, 1);
    chk("t3_outstanding", outstanding, 4);
    step(0, 0, 1, 1, 0);
    chk("t3_frozen_count", req_count, 0);
    chk("t3_no_valid", lat_valid, 0);
    chk("t3_popped", outstanding, 3);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1);
    chk("t3_clr_ovf", overflow, 0);
    chk("t3_clr_outstanding", outstanding, 0);
    chk("t3_clr_lat_min", lat_min, 255);

    // Completion with empty queue.
    step(0, 0, 1, 1, 0);
    chk("t4_underflow", underflow, 1);
    chk("t4_req_count", req_count, 0);
    chk("t4_no_valid", lat_valid, 0);
    step(0, 0, 0, 0, 1);

    // Timestamp wrap: 250 -> 4.
    wait_ts(250);
    step(1, 1, 0, 0, 0);
    wait_ts(4);
    step(0, 0, 1, 1, 0);
    chk("t5_wrap_lat", lat_last, 10);

    // Reset mid-request abandons it.
    step(0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    chk("t6_outstanding", outstanding, 1);
    aresetn = 0;
    @(negedge aclk);
    chk("t6_rst_outstanding", outstanding, 0);
    chk("t6_rst_lat_min", lat_min, 255);
    chk("t6_rst_lat_last", lat_last, 0);
    aresetn = 1;
    idle();
    step(0, 0, 1, 1, 0);
    chk("t6_underflow", underflow, 1);
    chk("t6_req_count", req_count, 0);

    // Same-cycle push and pop, multi-beat packets, enable gating, clear priority.
    step(0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 0);
    chk("t7_pushpop_outstanding", outstanding, 1);
    chk("t7_pushpop_lat", lat_last, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("t7_pkt_outstanding", outstanding, 3);
    enable = 0;
    step(1, 1, 1, 1, 0);
    chk("t7_disabled", outstanding, 3);
    enable = 1;
    step(1, 1, 1, 1, 1);
    chk("t7_clear_wins", outstanding, 0);
    chk("t7_clear_count", req_count, 0);

    // Saturation of request count and accumulator.
    for (int k = 0; k < 18; k++) begin
      step(1, 1, 0, 0, 0);
      repeat (69) idle();
      step(0, 0, 1, 1, 0);
    end
    chk("t8_lat_last", lat_last, 70);
    chk("t8_req_sat", req_count, 15);
    chk("t8_total_sat", lat_total, 1023);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
